gray_xfade_scheduler: RTL and testbench
=======================================

// Module: gray_xfade_scheduler
// PURPOSE
//  Frame-level crossfade sequencer in front of gray_weighted_merger.
//  Pairs two independent gray pixel streams and issues pairs no faster than 1 per 2 cycles (the merger's rate).
//  Ramps merger weights once per frame (weight1: 255->0, weight2 = 255-weight1). Weight sum is always 255, so the merger never divides by 0.
// PARAMETERS
//  FRAME_PIXELS  307200  pixel pairs per frame (640x480)
//  CNT_W         19      pixel counter width, >= clog2(FRAME_PIXELS)
//  DWELL_FRAMES  1       frames held at each weight before stepping (>=1)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   synchronous reset, active-high
//  start        in   1   begin ramp; ignored unless IDLE
//  stop         in   1   end ramp after current frame completes
//  cfg_step     in   8   weight decrement per step, latched at start; 0 treated as 1
//  in1_gray     in   8   stream 1 pixel
//  in1_valid    in   1   stream 1 valid
//  in1_ready    out  1   stream 1 ready
//  in2_gray     in   8   stream 2 pixel
//  in2_valid    in   1   stream 2 valid
//  in2_ready    out  1   stream 2 ready
//  mrg_gray1    out  8   to merger gray1_in
//  mrg_gray2    out  8   to merger gray2_in
//  mrg_valid    out  1   to merger data1_valid and data2_valid; 1-cycle pulse
//  mrg_weight1  out  8   to merger weight1
//  mrg_weight2  out  8   to merger weight2
//  busy         out  1   high when not IDLE
//  frame_done   out  1   1-cycle pulse after last pair of a frame issues
//  done         out  1   1-cycle pulse when ramp ends
// BEHAVIOUR
//  Reset values: all outputs 0, except mrg_weight1=255 and mrg_weight2=0. Holding regs, counters and step are cleared.
//  States: IDLE -> RUN (on start) -> DONE (1 cycle, done=1) -> IDLE.
//  IDLE: in1_ready=in2_ready=0; weights hold. start loads weight1=255, weight2=0, pixel count=0, dwell count=0.
//  RUN pairing: each side has a 1-deep holding reg. inN_ready = !heldN (registered). A side captures on valid&ready.
//  Issue: when both held and mrg_valid was 0 last cycle, mrg_valid=1 with both held pixels; both held regs clear in that cycle.
//   => Sustained throughput is 1 pair per 2 cycles. mrg_valid is never high on 2 consecutive cycles.
//  Pixel counter counts issued pairs. On the issue of pair FRAME_PIXELS-1:
//   - counter wraps to 0; frame_done=1 next cycle; dwell count increments.
//   - If dwell reaches DWELL_FRAMES: dwell count clears; weight1 = sat0(weight1-step); weight2 = 255-weight1 (updated next cycle).
//  Weights change only between frames. The 2-cycle issue gap guarantees the first pair of the next frame sees the new weights.
//  End: at a frame end with weight1==0 already before the update (the 0-weight frame is complete), or with stop seen since last frame end -> DONE.
//  stop in IDLE is ignored. stop and frame end in the same cycle -> DONE at that boundary.
//  Pending held pixels at DONE are discarded. Weights keep their final values.
//  Streams out of step: a side with a held pixel stalls (ready=0) until its partner arrives. No pixel is dropped or reordered in RUN.
//  rst mid-frame: immediate return to reset values; merger output for the in-flight pair is don't-care.
// CONFIGURATION
//  GRAY_XFADE_PINGPONG_EN defined:
//   - at a frame end with weight1==0, direction flips to ascending (weight1 = sat255(weight1+step));
//   - at weight1==255, direction flips back;
//   - only stop (or rst) ends the ramp. done pulses only via stop.
//  Not defined: single descending ramp as above; no direction register exists.
// STRUCTURE
//  Package gray_xfade_pkg: state enum {IDLE,RUN,DONE}, WMAX=8'd255, localparam helpers for counter width.
//  Sub-module gray_pair_skid (two 1-deep holding regs, ready gen, 2-cycle issue spacing).
//  Top holds FSM, pixel/dwell counters, weight ramp.
// TESTING (bench uses FRAME_PIXELS=4, DWELL_FRAMES=1; model merger checks weights)
//  1. start, cfg_step=128, both streams valid every cycle -> weights 255/0 (4 pairs), 127/128, 0/255; done after 12 pairs; mrg_valid never back-to-back.
//  2. in1 valid every cycle, in2 every 5th cycle -> in1_ready low while held; pairs issue in order, no loss.
//  3. stop asserted during frame 1, step=16 -> frame completes (4 pairs), done pulses, weights stay 239/16.
//  4. cfg_step=0 -> behaves as step 1; weight1 after first frame = 254.
//  5. rst asserted mid-frame -> next cycle busy=0, readies 0, weights 255/0. start while RUN -> ignored.
//  6. PINGPONG_EN, step=255 -> weights 255,0,255,0 per frame; stop -> done at next frame end.

Source files
------------

// File: rtl/gray_xfade_pkg.sv
// Shared state encoding, weight limit and width/saturation helpers for the
// gray crossfade scheduler.
package gray_xfade_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xfade_state_e;

    localparam logic [7:0] WMAX = 8'd255;

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? WMAX : s[7:0];
    endfunction

endpackage

// File: rtl/gray_pair_skid.sv
// Pairs two gray pixel streams through 1-deep holding registers and issues at
// most one pair every two cycles to the merger.
module gray_pair_skid (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [7:0] in1_gray_i,
    input  logic       in1_valid_i,
    output logic       in1_ready_o,
    input  logic [7:0] in2_gray_i,
    input  logic       in2_valid_i,
    output logic       in2_ready_o,
    output logic [7:0] mrg_gray1_o,
    output logic [7:0] mrg_gray2_o,
    output logic       mrg_valid_o,
    output logic       issue_o
);

    logic       held1_q;
    logic       held2_q;
    logic [7:0] pix1_q;
    logic [7:0] pix2_q;
    logic [7:0] out1_q;
    logic [7:0] out2_q;
    logic       valid_q;
    logic       take1;
    logic       take2;

    // Handshake: a pixel transfers on a cycle where valid && ready; ready is
    // a function of registered state only, and valid must hold until taken.
    assign in1_ready_o = en_i & ~held1_q;
    assign in2_ready_o = en_i & ~held2_q;
    assign take1       = in1_valid_i & in1_ready_o;
    assign take2       = in2_valid_i & in2_ready_o;

    // Issue needs both sides held and a quiet output last cycle.
    assign issue_o = en_i & held1_q & held2_q & ~valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            held1_q <= 1'b0;
            held2_q <= 1'b0;
            pix1_q  <= 8'd0;
            pix2_q  <= 8'd0;
            out1_q  <= 8'd0;
            out2_q  <= 8'd0;
            valid_q <= 1'b0;
        end else if (!en_i) begin
            held1_q <= 1'b0;
            held2_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= issue_o;
            if (issue_o) begin
                out1_q  <= pix1_q;
                out2_q  <= pix2_q;
                held1_q <= 1'b0;
                held2_q <= 1'b0;
            end else begin
                if (take1) begin
                    held1_q <= 1'b1;
                    pix1_q  <= in1_gray_i;
                end
                if (take2) begin
                    held2_q <= 1'b1;
                    pix2_q  <= in2_gray_i;
                end
            end
        end
    end

    assign mrg_gray1_o = out1_q;
    assign mrg_gray2_o = out2_q;
    assign mrg_valid_o = valid_q;

endmodule

// File: rtl/gray_xfade_scheduler.sv
// Frame-level crossfade sequencer: pairs two gray streams and ramps merger
// weights once per dwell period. Optional macro GRAY_XFADE_PINGPONG_EN.
module gray_xfade_scheduler
    import gray_xfade_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19,
    parameter int DWELL_FRAMES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] cfg_step,
    input  logic [7:0] in1_gray,
    input  logic       in1_valid,
    output logic       in1_ready,
    input  logic [7:0] in2_gray,
    input  logic       in2_valid,
    output logic       in2_ready,
    output logic [7:0] mrg_gray1,
    output logic [7:0] mrg_gray2,
    output logic       mrg_valid,
    output logic [7:0] mrg_weight1,
    output logic [7:0] mrg_weight2,
    output logic       busy,
    output logic       frame_done,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam int             DW_W     = cnt_bits(DWELL_FRAMES);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL_FRAMES - 1);

    xfade_state_e     state_q;
    logic [7:0]       step_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [DW_W-1:0]  dwell_q;
    logic [7:0]       w1_q;
    logic [7:0]       w2_q;
    logic             frame_done_q;
    logic             done_q;
    logic             stop_seen_q;
    logic             run_en;
    logic             issue;
    logic             dwell_hit;
    logic             ramp_end;
    logic [7:0]       w1_d;
`ifdef GRAY_XFADE_PINGPONG_EN
    logic             asc_q;
    logic             asc_d;
`endif

    assign run_en    = (state_q == RUN);
    assign dwell_hit = (dwell_q == LAST_DW);

    gray_pair_skid u_skid (
        .clk         (clk),
        .rst         (rst),
        .en_i        (run_en),
        .in1_gray_i  (in1_gray),
        .in1_valid_i (in1_valid),
        .in1_ready_o (in1_ready),
        .in2_gray_i  (in2_gray),
        .in2_valid_i (in2_valid),
        .in2_ready_o (in2_ready),
        .mrg_gray1_o (mrg_gray1),
        .mrg_gray2_o (mrg_gray2),
        .mrg_valid_o (mrg_valid),
        .issue_o     (issue)
    );

`ifdef GRAY_XFADE_PINGPONG_EN
    // Direction flips at the rails; the flipped direction applies to this step.
    always_comb begin
        asc_d = asc_q;
        if (!asc_q && (w1_q == 8'd0)) begin
            asc_d = 1'b1;
        end else if (asc_q && (w1_q == WMAX)) begin
            asc_d = 1'b0;
        end
        w1_d = asc_d ? sat_add(w1_q, step_q) : sat_sub(w1_q, step_q);
    end

    assign ramp_end = stop_seen_q | stop;
`else
    always_comb begin
        w1_d = sat_sub(w1_q, step_q);
    end

    // The ramp ends once the full dwell at weight 0 has been shown.
    assign ramp_end = stop_seen_q | stop | (dwell_hit & (w1_q == 8'd0));
`endif

    // Weight/state update runs one cycle after the last pair issues, i.e. while
    // that pair is on the merger port, so it still sees the old weights and the
    // 2-cycle issue gap lets the next frame's first pair see the new ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            step_q       <= 8'd0;
            pix_cnt_q    <= '0;
            dwell_q      <= '0;
            w1_q         <= WMAX;
            w2_q         <= 8'd0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            stop_seen_q  <= 1'b0;
`ifdef GRAY_XFADE_PINGPONG_EN
            asc_q        <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        step_q      <= (cfg_step == 8'd0) ? 8'd1 : cfg_step;
                        w1_q        <= WMAX;
                        w2_q        <= 8'd0;
                        pix_cnt_q   <= '0;
                        dwell_q     <= '0;
                        stop_seen_q <= 1'b0;
`ifdef GRAY_XFADE_PINGPONG_EN
                        asc_q       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_seen_q <= 1'b1;
                    end
                    if (issue) begin
                        if (pix_cnt_q == LAST_PIX) begin
                            pix_cnt_q    <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                        end
                    end
                    if (frame_done_q) begin
                        stop_seen_q <= 1'b0;
                        if (dwell_hit) begin
                            dwell_q <= '0;
                            w1_q    <= w1_d;
                            w2_q    <= WMAX - w1_d;
`ifdef GRAY_XFADE_PINGPONG_EN
                            asc_q   <= asc_d;
`endif
                        end else begin
                            dwell_q <= dwell_q + 1'b1;
                        end
                        if (ramp_end) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mrg_weight1 = w1_q;
    assign mrg_weight2 = w2_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = frame_done_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray_xfade_scheduler.sv
// Self-checking bench for gray_xfade_scheduler with 4-pixel frames; pixel
// pairs and per-frame weights are checked by a scoreboard monitor.
module tb_gray_xfade_scheduler;

    localparam int FP = 4;
`ifdef GRAY_XFADE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cfg_step = 8'd0;
    logic [7:0] in1_gray = 8'd0;
    logic       in1_valid = 1'b0;
    logic       in1_ready;
    logic [7:0] in2_gray = 8'd0;
    logic       in2_valid = 1'b0;
    logic       in2_ready;
    logic [7:0] mrg_gray1;
    logic [7:0] mrg_gray2;
    logic       mrg_valid;
    logic [7:0] mrg_weight1;
    logic [7:0] mrg_weight2;
    logic       busy;
    logic       frame_done;
    logic       done;
    logic [1:0] dbg_state;

    gray_xfade_scheduler #(
        .FRAME_PIXELS (FP),
        .CNT_W        (3),
        .DWELL_FRAMES (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_step    (cfg_step),
        .in1_gray    (in1_gray),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in2_gray    (in2_gray),
        .in2_valid   (in2_valid),
        .in2_ready   (in2_ready),
        .mrg_gray1   (mrg_gray1),
        .mrg_gray2   (mrg_gray2),
        .mrg_valid   (mrg_valid),
        .mrg_weight1 (mrg_weight1),
        .mrg_weight2 (mrg_weight2),
        .busy        (busy),
        .frame_done  (frame_done),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Clock/reset
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp1_q[$];
    logic [7:0] exp2_q[$];
    int         pair_cnt = 0;
    int         frame_cnt = 0;
    int         done_cnt = 0;
    int         cur_step = 1;
    bit         prev_valid = 1'b0;
    logic [7:0] mon_e1;
    logic [7:0] mon_e2;
    logic [7:0] mon_w;

    // Reference weight1 after a number of completed frames (dwell of 1).
    function automatic logic [7:0] exp_w1_for(input int frames, input int step);
        int w;
        bit asc;
        w = 255;
        asc = 1'b0;
        for (int f = 0; f < frames; f++) begin
            if (!PP) begin
                w = (w > step) ? w - step : 0;
            end else if (!asc) begin
                if (w == 0) begin
                    asc = 1'b1;
                    w = (w + step > 255) ? 255 : w + step;
                end else begin
                    w = (w > step) ? w - step : 0;
                end
            end else begin
                if (w == 255) begin
                    asc = 1'b0;
                    w = (w > step) ? w - step : 0;
                end else begin
                    w = (w + step > 255) ? 255 : w + step;
                end
            end
        end
        return w[7:0];
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (mrg_valid) begin
                vectors++;
                if (prev_valid) begin
                    miscompares++;
                    $display("FAIL back_to_back: mrg_valid high on consecutive cycles at pair %0d", pair_cnt);
                end
                vectors++;
                if (exp1_q.size() == 0 || exp2_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pair_unexpected: got pair %0d, expected queues sizes %0d/%0d",
                             pair_cnt, exp1_q.size(), exp2_q.size());
                end else begin
                    mon_e1 = exp1_q.pop_front();
                    mon_e2 = exp2_q.pop_front();
                    mon_w  = exp_w1_for(pair_cnt / FP, cur_step);
                    vectors++;
                    if (mrg_gray1 !== mon_e1) begin
                        miscompares++;
                        $display("FAIL pair_gray1 #%0d: got %0d, expected %0d", pair_cnt, mrg_gray1, mon_e1);
                    end
                    vectors++;
                    if (mrg_gray2 !== mon_e2) begin
                        miscompares++;
                        $display("FAIL pair_gray2 #%0d: got %0d, expected %0d", pair_cnt, mrg_gray2, mon_e2);
                    end
                    vectors++;
                    if (mrg_weight1 !== mon_w) begin
                        miscompares++;
                        $display("FAIL pair_weight1 #%0d: got %0d, expected %0d", pair_cnt, mrg_weight1, mon_w);
                    end
                    vectors++;
                    if (mrg_weight2 !== 8'(255 - mon_w)) begin
                        miscompares++;
                        $display("FAIL pair_weight2 #%0d: got %0d, expected %0d", pair_cnt, mrg_weight2, 255 - mon_w);
                    end
                end
                pair_cnt++;
            end
            if (frame_done) frame_cnt++;
            if (done) done_cnt++;
            prev_valid = mrg_valid;
        end
    end

    // Driver tasks
    task automatic do_start(input logic [7:0] step);
        pair_cnt  = 0;
        frame_cnt = 0;
        done_cnt  = 0;
        exp1_q.delete();
        exp2_q.delete();
        cur_step  = (step == 8'd0) ? 1 : step;
        @(negedge clk);
        cfg_step = step;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in1_ready !== 1'b1 || in2_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_run: busy/rdy1/rdy2 got %b%b%b, expected 111", busy, in1_ready, in2_ready);
        end
    endtask

    task automatic drive_streams(input int n, input int p1, input int p2, input int stop_at,
                                 output int stall1);
        int  sent1 = 0;
        int  sent2 = 0;
        int  cyc = 0;
        bit  acc1 = 1'b0;
        bit  acc2 = 1'b0;
        bit  stopped = 1'b0;
        stall1 = 0;
        while ((sent1 < n || sent2 < n) && cyc < 2000) begin
            @(negedge clk);
            stop = 1'b0;
            if (acc1) begin in1_valid = 1'b0; acc1 = 1'b0; end
            if (acc2) begin in2_valid = 1'b0; acc2 = 1'b0; end
            if (!in1_valid && sent1 < n && (cyc % p1) == 0) begin
                in1_valid = 1'b1;
                in1_gray  = 8'($urandom_range(0, 255));
            end
            if (!in2_valid && sent2 < n && (cyc % p2) == 0) begin
                in2_valid = 1'b1;
                in2_gray  = 8'($urandom_range(0, 255));
            end
            if (in1_valid && !in1_ready) stall1++;
            if (in1_valid && in1_ready) begin exp1_q.push_back(in1_gray); sent1++; acc1 = 1'b1; end
            if (in2_valid && in2_ready) begin exp2_q.push_back(in2_gray); sent2++; acc2 = 1'b1; end
            if (stop_at >= 0 && sent2 == stop_at && !stopped) begin
                stop = 1'b1;
                stopped = 1'b1;
            end
            cyc++;
        end
        @(negedge clk);
        stop = 1'b0;
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        vectors++;
        if (sent1 < n || sent2 < n) begin
            miscompares++;
            $display("FAIL drive_timeout: sent %0d/%0d, expected %0d each", sent1, sent2, n);
        end
    endtask

    task automatic wait_pairs(input int n);
        int cyc = 0;
        while (pair_cnt < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (pair_cnt < n) begin
            miscompares++;
            $display("FAIL pair_timeout: got %0d pairs, expected %0d", pair_cnt, n);
        end
    endtask

    task automatic wait_done(input int exp_pairs);
        int         cyc = 0;
        logic [7:0] w;
        w = exp_w1_for(exp_pairs / FP, cur_step);
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done not seen, got %0d pairs, expected %0d", pair_cnt, exp_pairs);
        end
        vectors++;
        if (pair_cnt != exp_pairs || frame_cnt != exp_pairs / FP) begin
            miscompares++;
            $display("FAIL done_count: pairs/frames got %0d/%0d, expected %0d/%0d",
                     pair_cnt, frame_cnt, exp_pairs, exp_pairs / FP);
        end
        vectors++;
        if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
            miscompares++;
            $display("FAIL pixels_lost: %0d/%0d pixels never issued, expected 0", exp1_q.size(), exp2_q.size());
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || in1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: done/busy/rdy1 got %b%b%b, expected 000", done, busy, in1_ready);
        end
        vectors++;
        if (mrg_weight1 !== w || mrg_weight2 !== 8'(255 - w)) begin
            miscompares++;
            $display("FAIL final_weights: got %0d/%0d, expected %0d/%0d", mrg_weight1, mrg_weight2, w, 255 - w);
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, in1_ready, in2_ready, mrg_valid, frame_done, done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {busy, in1_ready, in2_ready, mrg_valid, frame_done, done});
        end
        vectors++;
        if (mrg_gray1 !== 8'd0 || mrg_gray2 !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_gray: got %0d/%0d, expected 0/0", mrg_gray1, mrg_gray2);
        end
        vectors++;
        if (mrg_weight1 !== 8'd255 || mrg_weight2 !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_weights: got %0d/%0d, expected 255/0", mrg_weight1, mrg_weight2);
        end
    endtask

    task automatic test_full_ramp();
        int stall;
        do_start(8'd128);
        drive_streams(12, 1, 1, -1, stall);
        wait_done(12);
    endtask

    task automatic test_uneven_streams();
        int stall;
        do_start(8'd128);
        drive_streams(8, 1, 5, 6, stall);
        vectors++;
        if (stall == 0) begin
            miscompares++;
            $display("FAIL in1_stall: got %0d stalled cycles, expected more than 0", stall);
        end
        wait_done(8);
    endtask

    task automatic test_stop();
        int stall;
        do_start(8'd16);
        drive_streams(4, 1, 1, 2, stall);
        wait_done(4);
    endtask

    task automatic test_step_zero();
        int stall;
        do_start(8'd0);
        drive_streams(8, 1, 1, 6, stall);
        wait_done(8);
    endtask

    task automatic test_reset_mid_frame();
        int stall;
        do_start(8'd64);
        drive_streams(2, 1, 1, -1, stall);
        wait_pairs(2);
        @(negedge clk);
        cfg_step = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_streams(2, 1, 1, -1, stall);
        wait_pairs(4);
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || mrg_weight1 !== 8'd191 || mrg_weight2 !== 8'd64) begin
            miscompares++;
            $display("FAIL start_ignored: busy/w1/w2 got %b/%0d/%0d, expected 1/191/64",
                     busy, mrg_weight1, mrg_weight2);
        end
        drive_streams(1, 1, 1, -1, stall);
        wait_pairs(5);
        @(negedge clk);
        in1_valid = 1'b1;
        in1_gray  = 8'hA5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in1_valid = 1'b0;
        vectors++;
        if ({busy, in1_ready, in2_ready, mrg_valid, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_flags: got %b, expected 00000", {busy, in1_ready, in2_ready, mrg_valid, done});
        end
        vectors++;
        if (mrg_weight1 !== 8'd255 || mrg_weight2 !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_mid_weights: got %0d/%0d, expected 255/0", mrg_weight1, mrg_weight2);
        end
        rst = 1'b0;
        exp1_q.delete();
        exp2_q.delete();
        @(negedge clk);
    endtask

    task automatic test_pingpong();
        int stall;
        do_start(8'd255);
        drive_streams(16, 1, 1, 14, stall);
        wait_done(16);
    endtask

    initial begin
        test_reset();
        if (!PP) test_full_ramp();
        test_uneven_streams();
        test_stop();
        test_step_zero();
        test_reset_mid_frame();
        if (PP) test_pingpong();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
